// File: rtl/weight_ram_loader.sv
// Byte-stream to 32-bit word loader for the weight RAM write port.
// Define WEIGHT_LOADER_CHECKSUM_EN to add a trailing checksum byte and err flag.
module weight_ram_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    CHECK
  } state_t;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam state_t LAST = CHECK;
`else
  localparam state_t LAST = DONE;
`endif

  state_t            state;
  state_t            nxt;
  logic [1:0]        idx;
  logic [23:0]       lo;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic              acc;

  assign acc    = in_valid & in_ready;
  assign ram_we = (state == WRITE);
  assign done   = (state == DONE);
  assign busy   = (state != IDLE);

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = (word_count == '0) ? LAST : COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (acc && idx == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        nxt = (rem == CNT_W'(1)) ? LAST : COLLECT;
      end
      DONE: begin
        nxt = IDLE;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (acc) nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      lo       <= '0;
      addr     <= '0;
      rem      <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        addr <= base_addr;
        rem  <= word_count;
        idx  <= '0;
      end
      if (state == COLLECT && acc) begin
        unique case (idx)
          2'd0: lo[7:0]   <= in_data;
          2'd1: lo[15:8]  <= in_data;
          2'd2: lo[23:16] <= in_data;
          2'd3: begin
            ram_din  <= {in_data, lo};
            ram_addr <= addr;
          end
          default: ;
        endcase
        idx <= idx + 2'd1;
      end
      // Address wraps naturally at 2^ADDR_W
      if (state == WRITE) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - CNT_W'(1);
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sum <= '0;
        err <= 1'b0;
      end
      if (state == COLLECT && acc) sum <= sum + in_data;
      if (state == CHECK && acc) err <= ((sum + in_data) != 8'h00);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_ram_loader.sv
// Self-checking bench for weight_ram_loader: vector table, corner
// sequences and randomized loads against a queue-based write model.
module tb_weight_ram_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  word_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        busy;
  logic        done;
  logic        err;

  weight_ram_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;
  int cyc = 0;
  int done_n;
  int done_cyc;
  int viol;
  int first_acc;
  int start_cyc;
  logic [41:0] wq[$];
  logic [7:0]  pay[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we) wq.push_back({ram_addr, ram_din});
    if (ram_we && in_ready) viol++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
  endfunction

  function automatic logic [7:0] good_chk(input int cnt);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 4 * cnt; i++) s = s + pay[i];
    return 8'h00 - s;
  endfunction

  task automatic run_load(input logic [9:0] base, input logic [9:0] cnt,
                          input int gap, input bit poke,
                          input logic [7:0] chkb);
    int j, n, total, budget;
    bit v, tog, poked;
    n = 4 * int'(cnt);
    total = n + (CHK ? 1 : 0);
    wq.delete();
    done_n = 0;
    viol = 0;
    first_acc = -1;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    word_count = cnt;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    j = 0;
    budget = 0;
    tog = 1'b0;
    poked = 1'b0;
    while (j < total && budget < 2000) begin
      case (gap)
        0: v = 1'b1;
        1: v = ~tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      in_valid = v;
      in_data = (j < n) ? pay[j] : chkb;
      if (poke && !poked && j == 2) begin
        start = 1'b1;
        base_addr = 10'h155;
        word_count = 10'd7;
        poked = 1'b1;
      end else begin
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        j++;
      end
      budget++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (j < total) begin
      nbad++;
      ncmp++;
      $display("FAIL stream_timeout: got %0d bytes want %0d", j, total);
    end
    budget = 0;
    while (done_n == 0 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    if (done_n == 0) begin
      nbad++;
      ncmp++;
      $display("FAIL done_timeout: got 0 pulses want 1");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic verify(input logic [9:0] base, input int cnt,
                        input logic exp_err);
    logic [9:0] a;
    check("wr_count", 64'(wq.size()), 64'(cnt));
    for (int i = 0; i < wq.size() && i < cnt; i++) begin
      a = base + 10'(i);
      check("wr_addr", 64'(wq[i][41:32]), 64'(a));
      check("wr_data", 64'(wq[i][31:0]), 64'(word_of(i)));
    end
    check("done_pulses", 64'(done_n), 64'd1);
    check("ready_in_write", 64'(viol), 64'd0);
    check("err", 64'(err), 64'(exp_err));
    check("busy_after", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [9:0]  base;
    logic [9:0]  cnt;
    int          gap;
    bit          poke;
    logic [9:0]  a0_exp;
    logic [31:0] d0_exp;
    logic [9:0]  alast_exp;
    int          lat_exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [9:0] rb;
    logic [9:0] rc;
    logic [7:0] cb;
    bit bad;

    vt[0] = '{10'h010, 10'd2, 0, 1'b0, 10'h010, 32'h04030201, 10'h011, 10};
    vt[1] = '{10'h010, 10'd2, 1, 1'b0, 10'h010, 32'h04030201, 10'h011, -1};
    vt[2] = '{10'h3FF, 10'd2, 0, 1'b0, 10'h3FF, 32'h04030201, 10'h000, 10};
    vt[3] = '{10'h020, 10'd3, 0, 1'b1, 10'h020, 32'h04030201, 10'h022, 15};

    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    in_data = '0;
    in_valid = 1'b0;
    #1;
    check("reset_outputs",
          64'({in_ready, ram_we, ram_addr, ram_din, busy, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i + 1));
    foreach (vt[k]) begin
      run_load(vt[k].base, vt[k].cnt, vt[k].gap, vt[k].poke,
               good_chk(int'(vt[k].cnt)));
      verify(vt[k].base, int'(vt[k].cnt), 1'b0);
      if (wq.size() > 0) begin
        check("vec_first_addr", 64'(wq[0][41:32]), 64'(vt[k].a0_exp));
        check("vec_first_data", 64'(wq[0][31:0]), 64'(vt[k].d0_exp));
        check("vec_last_addr", 64'(wq[wq.size()-1][41:32]),
              64'(vt[k].alast_exp));
      end
      if (vt[k].lat_exp >= 0)
        check("vec_latency", 64'(done_cyc - first_acc),
              64'(vt[k].lat_exp + (CHK ? 1 : 0)));
    end

    run_load(10'h050, 10'd0, 0, 1'b0, 8'h00);
    verify(10'h050, 0, 1'b0);
    if (!CHK)
      check("zero_done_delay",
            64'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2),
            64'd1);

    wq.delete();
    @(negedge clk);
    start = 1'b1;
    base_addr = 10'h040;
    word_count = 10'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hAA;
    @(negedge clk);
    in_data = 8'hBB;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset_outputs",
          64'({in_ready, ram_we, ram_addr, ram_din, busy, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    check("midreset_no_write", 64'(wq.size()), 64'd0);
    reset = 1'b1;
    run_load(10'h040, 10'd2, 0, 1'b0, good_chk(2));
    verify(10'h040, 2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rb = 10'($urandom);
      rc = 10'($urandom_range(1, 5));
      pay.delete();
      for (int i = 0; i < 4 * int'(rc); i++) pay.push_back(8'($urandom));
      bad = CHK && 1'($urandom_range(0, 1));
      cb = good_chk(int'(rc)) + (bad ? 8'h01 : 8'h00);
      run_load(rb, rc, int'($urandom_range(0, 2)), 1'b0, cb);
      verify(rb, int'(rc), bad);
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'(i + 1));
    run_load(10'h100, 10'd1, 0, 1'b0, 8'hF6);
    verify(10'h100, 1, 1'b0);
    run_load(10'h100, 10'd1, 0, 1'b0, 8'hF5);
    verify(10'h100, 1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    base_addr = '0;
    word_count = '0;
    @(negedge clk);
    start = 1'b0;
    check("err_clear", 64'(err), 64'd0);
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("zero_chk_idle", 64'(busy), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
